// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction-fetch stage for a single-cycle RV32I datapath. Holds the PC,
//   fetches one instruction over a req/ack handshake, presents it with its PC
//   and PC+4, and on retire selects the next PC from the decoder's PCSrc.
//   A misaligned next PC freezes the unit in FAULT until reset.
//
// Parameters
//   RESET_PC   : PC loaded on reset (4-byte aligned)
//   NOP_INSTR  : value held on Instr while no valid instruction is present
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   PCSrc           : 00/11 PC+4, 01 PCTarget, 10 ALUResult (JALR)
//   PCTarget        : branch/JAL target
//   ALUResult       : JALR target (bit 0 is cleared)
//   retire          : presented instruction finished; PCSrc/targets valid
//   imem_req        : fetch request
//   imem_addr       : fetch address (equals PC)
//   imem_ack        : imem_rdata valid this cycle
//   imem_rdata      : fetched instruction word
//   instr_valid     : Instr / PC / PCPlus4 are valid
//   Instr           : registered instruction
//   PC, PCPlus4     : address of Instr and that address + 4
//   misalign_fault  : sticky misaligned-next-PC flag
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] PCTarget,
   input  logic [31:0] ALUResult,
   input  logic        retire,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        misalign_fault
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] next_pc;

   assign PCPlus4   = PC + 32'd4;
   assign imem_addr = PC;

   // Next-PC mux; JALR target has bit 0 forced to zero.
   always_comb begin
      // NOTE: default assignment first so no path leaves next_pc unassigned,
      // which would otherwise infer a latch.
      next_pc = PCPlus4;
      case (PCSrc)
         2'b01:   next_pc = PCTarget;
         2'b10:   next_pc = ALUResult & ~32'd1;
         default: next_pc = PCPlus4;
      endcase
   end

   // imem_req is a registered output, so it is set on the transition into
   // REQ and cleared on the transition out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= BOOT;
         PC             <= RESET_PC;
         Instr          <= NOP_INSTR;
         imem_req       <= 1'b0;
         instr_valid    <= 1'b0;
         misalign_fault <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all registered state so every
         // branch sees the pre-edge values regardless of statement order.
         case (state)
            BOOT: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               if (imem_ack) begin
                  Instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (retire) begin
                  instr_valid <= 1'b0;
                  if (next_pc[1:0] == 2'b00) begin
                     PC       <= next_pc;
                     Instr    <= NOP_INSTR;
                     imem_req <= 1'b1;
                     state    <= REQ;
                  end else begin
                     // PC and Instr are left as they were for post-mortem.
                     misalign_fault <= 1'b1;
                     state          <= FAULT;
                  end
               end
            end
            FAULT: begin
               // Frozen until reset.
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule
